// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: resolves redirects, load-use, divide and bus-wait stalls,
// and keeps a saturating count of stalled cycles.
module pipe_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        load_use_i,
  input  logic        div_req_i,
  input  logic        div_done_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        div_start_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StBus
  } state_e;

  localparam logic [7:0] WaitLast = 8'(BUS_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    jump_en_o     = 1'b0;
    jump_addr_o   = '0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    div_start_o   = 1'b0;
    bus_err_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (jump_en_i) begin
          jump_en_o     = 1'b1;
          jump_addr_o   = jump_addr_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (div_req_i) begin
          div_start_o   = 1'b1;
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
          state_d       = StDiv;
        end else if (mem_req_i && !mem_ack_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
          wait_d        = '0;
          state_d       = StBus;
        end else if (load_use_i) begin
          // Bubble into EX while the load completes; ID holds the consumer.
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end
      end

      StDiv: begin
        if (div_done_i) begin
          state_d = StIdle;
        end else begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
        end
      end

      StBus: begin
        if (mem_ack_i) begin
          state_d = StIdle;
        end else if (wait_q == WaitLast) begin
          // Abort: drop the stalled memory op from EX and let the pipe run on.
          bus_err_o     = 1'b1;
          flush_id_ex_o = 1'b1;
          state_d       = StIdle;
        end else begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
          wait_d        = wait_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase

    // Outputs are released the instant reset asserts, even mid-operation.
    if (!rstn) begin
      jump_en_o     = 1'b0;
      jump_addr_o   = '0;
      stall_pc_o    = 1'b0;
      stall_if_id_o = 1'b0;
      stall_id_ex_o = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      div_start_o   = 1'b0;
      bus_err_o     = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  a_id_ex_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(flush_id_ex_o && stall_id_ex_o));
  a_if_id_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(flush_if_id_o && stall_if_id_o));
  a_addr_zero: assert property (@(posedge clk) disable iff (!rstn)
    !jump_en_o |-> (jump_addr_o == '0));
  a_start_pulse: assert property (@(posedge clk) disable iff (!rstn)
    div_start_o |=> !div_start_o);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        load_use = 1'b0;
  logic        div_req = 1'b0;
  logic        div_done = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ack = 1'b0;

  logic        jump_en_out;
  logic [31:0] jump_addr_out;
  logic        stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex;
  logic        div_start, bus_err;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.BUS_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .load_use_i   (load_use),
    .div_req_i    (div_req),
    .div_done_i   (div_done),
    .mem_req_i    (mem_req),
    .mem_ack_i    (mem_ack),
    .jump_en_o    (jump_en_out),
    .jump_addr_o  (jump_addr_out),
    .stall_pc_o   (stall_pc),
    .stall_if_id_o(stall_if_id),
    .stall_id_ex_o(stall_id_ex),
    .flush_if_id_o(flush_if_id),
    .flush_id_ex_o(flush_id_ex),
    .div_start_o  (div_start),
    .bus_err_o    (bus_err),
    .stall_cnt_o  (stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: what operation is outstanding, how long the bus has waited, stall total.
  bit          m_div_busy;
  bit          m_bus_busy;
  int          m_bus_waited;
  logic [31:0] m_cnt;

  logic        e_jump, e_spc, e_sifid, e_sidex, e_fifid, e_fidex, e_dstart, e_berr;
  logic [31:0] e_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_stall_all();
    e_spc = 1'b1; e_sifid = 1'b1; e_sidex = 1'b1;
  endtask

  task automatic model_eval();
    {e_jump, e_spc, e_sifid, e_sidex, e_fifid, e_fidex, e_dstart, e_berr} = '0;
    e_addr = '0;
    if (!rstn) begin
      m_div_busy = 0; m_bus_busy = 0; m_bus_waited = 0; m_cnt = '0;
    end else if (m_div_busy) begin
      if (!div_done) set_stall_all();
    end else if (m_bus_busy) begin
      if (!mem_ack) begin
        if (m_bus_waited + 1 == TO) begin
          e_berr = 1'b1; e_fidex = 1'b1;
        end else begin
          set_stall_all();
        end
      end
    end else if (jump_en) begin
      e_jump = 1'b1; e_addr = jump_addr; e_fifid = 1'b1; e_fidex = 1'b1;
    end else if (div_req) begin
      e_dstart = 1'b1; set_stall_all();
    end else if (mem_req && !mem_ack) begin
      set_stall_all();
    end else if (load_use) begin
      e_spc = 1'b1; e_sifid = 1'b1; e_fidex = 1'b1;
    end
  endtask

  task automatic sample();
    #1;
    model_eval();
    chk("flags", {24'd0, jump_en_out, stall_pc, stall_if_id, stall_id_ex, flush_if_id,
                  flush_id_ex, div_start, bus_err},
                 {24'd0, e_jump, e_spc, e_sifid, e_sidex, e_fifid, e_fidex, e_dstart, e_berr});
    chk("jump_addr", jump_addr_out, e_addr);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rstn) begin
      if (e_spc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_div_busy) begin
        if (div_done) m_div_busy = 0;
      end else if (m_bus_busy) begin
        if (mem_ack || m_bus_waited + 1 == TO) m_bus_busy = 0;
        else m_bus_waited++;
      end else if (!jump_en) begin
        if (div_req) m_div_busy = 1;
        else if (mem_req && !mem_ack) begin
          m_bus_busy = 1; m_bus_waited = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic j, input logic [31:0] a, input logic lu, input logic dr,
                       input logic dd, input logic mr, input logic ma);
    jump_en = j; jump_addr = a; load_use = lu; div_req = dr; div_done = dd;
    mem_req = mr; mem_ack = ma;
  endtask

  initial begin
    int stall_seen;
    int err_seen;
    int ack_thresh;

    // Reset state
    @(negedge clk);
    sample();
    chk("rst_flags", {24'd0, jump_en_out, stall_pc, stall_if_id, stall_id_ex, flush_if_id,
                      flush_id_ex, div_start, bus_err}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    advance();
    rstn = 1'b1;

    // Jump redirect
    drive(1, 32'h0000_0100, 0, 0, 0, 0, 0);
    sample();
    chk("jmp_en", {31'd0, jump_en_out}, 32'd1);
    chk("jmp_addr", jump_addr_out, 32'h100);
    chk("jmp_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
    chk("jmp_nostall", {29'd0, stall_pc, stall_if_id, stall_id_ex}, 32'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("jmp_cnt", stall_cnt, 32'd0);
    chk("jmp_addr_zero", jump_addr_out, 32'd0);
    advance();

    // Divide: request at cycle 0, done at cycle 33
    for (int c = 0; c <= 33; c++) begin
      drive(0, 0, 0, 1, (c == 33), 0, 0);
      sample();
      chk("div_start", {31'd0, div_start}, (c == 0) ? 32'd1 : 32'd0);
      chk("div_stalls", {29'd0, stall_pc, stall_if_id, stall_id_ex}, (c < 33) ? 32'd7 : 32'd0);
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("div_cnt", stall_cnt, 32'd33);
    advance();

    // Bus timeout with ack held low
    stall_seen = 0;
    err_seen = 0;
    for (int c = 0; c <= 16; c++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      sample();
      if (stall_pc) stall_seen++;
      if (bus_err) begin
        err_seen++;
        chk("to_err_cycle", c, 16);
        chk("to_flush", {31'd0, flush_id_ex}, 32'd1);
        chk("to_nostall", {29'd0, stall_pc, stall_if_id, stall_id_ex}, 32'd0);
      end
      advance();
    end
    chk("to_stall_cycles", stall_seen, 16);
    chk("to_err_pulses", err_seen, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("to_cnt", stall_cnt, 32'd49);
    chk("to_idle", {29'd0, stall_pc, stall_if_id, stall_id_ex}, 32'd0);
    advance();

    // Simultaneous jump, divide and load-use: jump only
    drive(1, 32'hDEAD_BEE0, 1, 1, 0, 0, 0);
    sample();
    chk("sim_jump", {31'd0, jump_en_out}, 32'd1);
    chk("sim_addr", jump_addr_out, 32'hDEAD_BEE0);
    chk("sim_nodiv", {30'd0, div_start, stall_pc}, 32'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("sim_idle", {29'd0, stall_pc, stall_if_id, stall_id_ex}, 32'd0);
    advance();

    // Load-use bubble, then reset in the middle of a divide
    drive(0, 0, 1, 0, 0, 0, 0);
    sample();
    chk("lu_out", {28'd0, stall_pc, stall_if_id, flush_id_ex, stall_id_ex}, 32'b1110);
    advance();
    drive(0, 0, 0, 1, 0, 0, 0);
    sample();
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      sample();
      advance();
    end
    sample();
    chk("mid_div_stall", {31'd0, stall_pc}, 32'd1);
    rstn = 1'b0;
    sample();
    chk("rst_div_flags", {24'd0, jump_en_out, stall_pc, stall_if_id, stall_id_ex, flush_if_id,
                          flush_id_ex, div_start, bus_err}, 32'd0);
    chk("rst_div_cnt", stall_cnt, 32'd0);
    advance();
    rstn = 1'b1;
    sample();
    chk("post_rst_idle", {31'd0, stall_pc}, 32'd0);
    advance();

    // Saturation from a preloaded counter
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      sample();
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);
    advance();
    sample();
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    advance();

    // Randomized traffic with occasional asynchronous resets
    ack_thresh = 32;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_thresh = 32;
          1: ack_thresh = 4;
          default: ack_thresh = 1;
        endcase
      end
      rstn = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 63) < ack_thresh);
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
